// File: rtl/s_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : s_uart_rx
// Description : Serial receiver for the one-clock-per-bit s_UART link.
//               Frame: idle 0, start 1, DATA_BITS data bits LSB first,
//               stop 0. Bytes are delivered on a level valid/ack handshake.
//               Bad stop bits pulse frame_err; overwritten bytes set overrun.
// Ports       : clk       - system clock (rising edge)
//               rst       - asynchronous active-low reset
//               rxd       - serial line, idle level 0
//               ack       - consumer acknowledge, clears valid and overrun
//               data_out  - last received byte
//               valid     - data_out holds an unacknowledged byte
//               frame_err - one-cycle pulse on a bad stop bit
//               overrun   - sticky, a byte was overwritten before ack
//               busy      - receiver inside a frame or in error recovery
// Revision    : 1.0 - initial release
// ============================================================================
module s_uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_BITS - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DATA     = 2'd1;
    localparam logic [1:0] c_STOP     = 2'd2;
    localparam logic [1:0] c_ERR_WAIT = 2'd3;

    logic                 w_rxd_s;
    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_commit;
    logic                 w_bad_stop;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    // ------------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_rxd_s = rxd;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= rxd;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_rxd_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_bad_stop   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_rxd_s) begin
                    w_next_state = c_DATA;
                end
            end
            c_DATA: begin
                if (r_bit_cnt == c_LAST) begin
                    w_next_state = c_STOP;
                end
            end
            c_STOP: begin
                if (w_rxd_s) begin
                    w_bad_stop   = 1'b1;
                    w_next_state = c_ERR_WAIT;
                end else begin
                    w_commit     = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            c_ERR_WAIT: begin
                // Hold off until the line drops so a stuck-high line
                // cannot be mistaken for a stream of start bits.
                if (!w_rxd_s) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_state == c_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == c_DATA) begin
                r_shift[r_bit_cnt] <= w_rxd_s;
                // Explicit wrap keeps non power-of-two widths correct.
                r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + 1'b1;
            end

            if (w_commit) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (ack) begin
                r_valid <= 1'b0;
            end

            // A commit acknowledged on the same edge replaces a byte the
            // consumer has already taken, so it is not an overrun.
            if (w_commit && r_valid && !ack) begin
                r_overrun <= 1'b1;
            end else if (ack) begin
                r_overrun <= 1'b0;
            end

            r_frame_err <= w_bad_stop;
            r_busy      <= (w_next_state != c_IDLE);
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_s_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_uart_rx
// Description : Self-checking bench for s_uart_rx. Two instances (SYNC_STAGES
//               2 and 0) share one serial line. Frames are laid out on a
//               cycle timeline; the expected commit / error / busy events
//               are derived from frame positions and the stated latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_uart_rx;

    localparam int N  = 1600;
    localparam int NA = N + 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b0;
    logic       ack2 = 1'b0;
    logic       ack0 = 1'b0;
    logic [7:0] dout2, dout0;
    logic       valid2, valid0, ferr2, ferr0, ovr2, ovr0, busy2, busy0;

    int n_total = 0;
    int n_bad   = 0;

    int         sync_of [2] = '{2, 0};
    bit         tl_rxd   [NA];
    bit         tl_ack   [2][NA];
    bit         ev_commit[2][NA];
    logic [7:0] ev_byte  [2][NA];
    bit         ev_bad   [2][NA];
    bit         ex_busy  [2][NA];
    int         p;

    s_uart_rx #(.SYNC_STAGES(2), .DATA_BITS(8)) u_dut2 (
        .clk(clk), .rst(rst), .rxd(rxd), .ack(ack2),
        .data_out(dout2), .valid(valid2), .frame_err(ferr2),
        .overrun(ovr2), .busy(busy2)
    );

    s_uart_rx #(.SYNC_STAGES(0), .DATA_BITS(8)) u_dut0 (
        .clk(clk), .rst(rst), .rxd(rxd), .ack(ack0),
        .data_out(dout0), .valid(valid0), .frame_err(ferr0),
        .overrun(ovr0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dout2"},  32'(dout2),  0);
        chk({tag, " valid2"}, 32'(valid2), 0);
        chk({tag, " ferr2"},  32'(ferr2),  0);
        chk({tag, " ovr2"},   32'(ovr2),   0);
        chk({tag, " busy2"},  32'(busy2),  0);
        chk({tag, " dout0"},  32'(dout0),  0);
        chk({tag, " valid0"}, 32'(valid0), 0);
        chk({tag, " ferr0"},  32'(ferr0),  0);
        chk({tag, " ovr0"},   32'(ovr0),   0);
        chk({tag, " busy0"},  32'(busy0),  0);
    endtask

    task automatic clear_tl();
        for (int k = 0; k < NA; k++) begin
            tl_rxd[k] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                tl_ack[d][k]    = 1'b0;
                ev_commit[d][k] = 1'b0;
                ev_byte[d][k]   = 8'h00;
                ev_bad[d][k]    = 1'b0;
                ex_busy[d][k]   = 1'b0;
            end
        end
        p = 2;
    endtask

    // Lay one frame at position p. A bad frame keeps the line high for
    // 'hold' cycles starting at the stop bit. 'gap' is the idle count
    // before the next start bit. Returns the stop-bit index.
    task automatic add_frame(input logic [7:0] b, input bit good, input int hold,
                             input int gap, output int stop);
        int s0, z;
        s0 = p;
        tl_rxd[s0] = 1'b1;
        for (int i = 0; i < 8; i++) tl_rxd[s0+1+i] = b[i];
        stop = s0 + 9;
        if (good) begin
            tl_rxd[stop] = 1'b0;
            z = stop;
        end else begin
            for (int h = 0; h < hold; h++) tl_rxd[stop+h] = 1'b1;
            z = stop + hold;
        end
        for (int d = 0; d < 2; d++) begin
            int s;
            s = sync_of[d];
            if (good) begin
                ev_commit[d][stop+s] = 1'b1;
                ev_byte[d][stop+s]   = b;
                for (int e = s0 + s; e < stop + s; e++) ex_busy[d][e] = 1'b1;
            end else begin
                ev_bad[d][stop+s] = 1'b1;
                for (int e = s0 + s; e < z + s; e++) ex_busy[d][e] = 1'b1;
            end
        end
        p = good ? (stop + 1 + gap) : (z + gap);
    endtask

    // Input index k is driven before edge k and sampled on it; outputs are
    // checked just after edge k against the handshake model.
    task automatic run_tl(input int n);
        bit         mv [2];
        bit         mo [2];
        logic [7:0] md [2];
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mo[d] = 1'b0; md[d] = 8'h00;
        end
        for (int k = 1; k <= n; k++) begin
            rxd  = tl_rxd[k];
            ack2 = tl_ack[0][k];
            ack0 = tl_ack[1][k];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                bit a;
                a = tl_ack[d][k];
                if (ev_commit[d][k]) begin
                    if (mv[d] && !a) mo[d] = 1'b1;
                    else if (a)      mo[d] = 1'b0;
                    md[d] = ev_byte[d][k];
                    mv[d] = 1'b1;
                end else if (a) begin
                    mv[d] = 1'b0;
                    mo[d] = 1'b0;
                end
                chk($sformatf("s%0d data@%0d",  sync_of[d], k), 32'(d == 0 ? dout2  : dout0),  32'(md[d]));
                chk($sformatf("s%0d valid@%0d", sync_of[d], k), 32'(d == 0 ? valid2 : valid0), 32'(mv[d]));
                chk($sformatf("s%0d ovr@%0d",   sync_of[d], k), 32'(d == 0 ? ovr2   : ovr0),   32'(mo[d]));
                chk($sformatf("s%0d ferr@%0d",  sync_of[d], k), 32'(d == 0 ? ferr2  : ferr0),  32'(ev_bad[d][k]));
                chk($sformatf("s%0d busy@%0d",  sync_of[d], k), 32'(d == 0 ? busy2  : busy0),  32'(ex_busy[d][k]));
            end
        end
    endtask

    initial begin
        int         st;
        int         rstart;
        logic [7:0] part;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Directed frames followed by randomized traffic
        clear_tl();
        add_frame(8'hA5, 1'b1, 0, 3, st);
        tl_ack[0][st+4] = 1'b1; tl_ack[1][st+4] = 1'b1;
        add_frame(8'h3C, 1'b0, 5, 2, st);
        add_frame(8'h11, 1'b1, 0, 1, st);
        add_frame(8'h22, 1'b1, 0, 4, st);
        tl_ack[0][st+4] = 1'b1; tl_ack[1][st+4] = 1'b1;
        add_frame(8'h55, 1'b1, 0, 2, st);
        add_frame(8'h66, 1'b1, 0, 3, st);
        for (int d = 0; d < 2; d++) tl_ack[d][st+sync_of[d]] = 1'b1;
        tl_ack[0][st+5] = 1'b1; tl_ack[1][st+5] = 1'b1;
        add_frame(8'hFF, 1'b1, 0, 1, st);
        add_frame(8'h00, 1'b1, 0, 3, st);
        rstart = p;
        while (p < N - 30) begin
            add_frame(8'($urandom), ($urandom % 6) != 0, $urandom_range(1, 5),
                      $urandom_range(1, 4), st);
        end
        for (int k = rstart; k <= N; k++) begin
            tl_ack[0][k] = ($urandom % 4) == 0;
            tl_ack[1][k] = ($urandom % 4) == 0;
        end
        run_tl(N);

        // Reset asserted during data bit 4 of a partial frame
        part = 8'hC3;
        rxd = 1'b1; ack2 = 1'b0; ack0 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rxd = part[i];
            @(posedge clk); #1;
        end
        rxd = part[4];
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rst_rel");

        // Clean frame after the mid-frame reset
        clear_tl();
        add_frame(8'h81, 1'b1, 0, 5, st);
        run_tl(30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
